// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle of the next-PC sequencer: control requests in, fetch address/qualifiers out.
// master = the sequencer, slave = whoever drives requests and consumes the fetch stream.
interface pc_sequencer_if;
  logic        start;
  logic        stall;
  logic        br_taken;
  logic [63:0] br_target;
  logic        exc;
  logic [63:0] pc;
  logic        pc_valid;
  logic        flush;
  logic [1:0]  state;

  modport master (
    input  start, stall, br_taken, br_target, exc,
    output pc, pc_valid, flush, state
  );

  modport slave (
    output start, stall, br_taken, br_target, exc,
    input  pc, pc_valid, flush, state
  );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC sequencer: owns the fetch PC, chooses hold / PC+4 / branch / exception and sequences redirect flushes.
// Optional misaligned-redirect trap enabled by defining PC_ALIGN_CHECK_EN.
module pc_sequencer #(
  parameter logic [63:0] RESET_PC     = 64'h0,
  parameter logic [63:0] EXC_VECTOR   = 64'h0000_0000_0000_0100,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  pc_sequencer_if.master  bus
);

`ifdef PC_ALIGN_CHECK_EN
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    FLUSH = 2'b10,
    FAULT = 2'b11
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    FLUSH = 2'b10
  } state_e;
`endif

  localparam logic [3:0] CNT_RELOAD = 4'(FLUSH_CYCLES - 1);

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        pc_valid_q, pc_valid_d;
  logic        flush_q, flush_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        in_bubble;
  logic        exc_hit;
  logic        br_hit;
  logic        redir_req;
  logic [63:0] redir_tgt;

  // Fetch contract: pc_valid=1 means pc is a real fetch the pipeline must
  // execute this cycle; there is no ready, back-pressure arrives via stall,
  // which only freezes sequential advance and never blocks a redirect.
  always_comb begin
    in_bubble = (state_q == FLUSH);
`ifdef PC_ALIGN_CHECK_EN
    in_bubble = in_bubble || (state_q == FAULT);
`endif
    exc_hit   = bus.exc && ((state_q == RUN) || in_bubble);
    // Branches seen during a bubble come from wrong-path instructions.
    br_hit    = bus.br_taken && (state_q == RUN);
    redir_req = exc_hit || br_hit;
    redir_tgt = exc_hit ? EXC_VECTOR : bus.br_target;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_valid_d = pc_valid_q;
    flush_d    = flush_q;
    cnt_d      = cnt_q;

    case (state_q)
      IDLE: begin
        pc_d       = RESET_PC;
        pc_valid_d = 1'b0;
        flush_d    = 1'b0;
        if (bus.start) begin
          state_d    = RUN;
          pc_valid_d = 1'b1;
        end
      end
      RUN: begin
        pc_valid_d = 1'b1;
        flush_d    = 1'b0;
        if (!bus.stall) begin
          pc_d = pc_q + 64'd4;
        end
      end
      default: begin
        // FLUSH / FAULT: pc already holds the target, so leaving on count 0
        // makes the target the first fetch.
        pc_valid_d = 1'b0;
        flush_d    = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d    = RUN;
          pc_valid_d = 1'b1;
          flush_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
    endcase

    if (redir_req) begin
      state_d    = FLUSH;
      pc_d       = redir_tgt;
      pc_valid_d = 1'b0;
      flush_d    = 1'b1;
      cnt_d      = CNT_RELOAD;
`ifdef PC_ALIGN_CHECK_EN
      if (redir_tgt[1:0] != 2'b00) begin
        state_d = FAULT;
        pc_d    = {EXC_VECTOR[63:2], 2'b00};
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      pc_valid_q <= 1'b0;
      flush_q    <= 1'b0;
      cnt_q      <= 4'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      flush_q    <= flush_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_valid = pc_valid_q;
  assign bus.flush    = flush_q;
  assign bus.state    = state_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-PC controller that owns the 64-bit program counter register of the pipelined processor.
- Selects each cycle between:
  - hold, for a fetch/decode stall;
  - sequential PC+4;
  - taken-branch redirect from EX;
  - exception vector.
- Sequences a fixed-length pipeline flush after every redirect.
- Feeds the instruction-fetch stage: fetch address on pc, qualifier on pc_valid, and flush to the IF/ID pipeline registers.

Parameters:
- RESET_PC, 64'h0, PC value loaded by reset and held in IDLE.
- EXC_VECTOR, 64'h0000_0000_0000_0100, target loaded on exception.
- FLUSH_CYCLES, 2, bubble cycles after any redirect; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  leave IDLE and begin fetching at RESET_PC.
- stall  input  1  hold PC (hazard unit).
- br_taken  input  1  taken branch resolved in EX; redirect to br_target.
- br_target  input  64  absolute branch target.
- exc  input  1  exception request; redirect to EXC_VECTOR.
- pc  output  64  current fetch address (registered).
- pc_valid  output  1  pc is a fetch the pipeline must execute.
- flush  output  1  squash wrong-path instructions in IF/ID.
- state  output  2  00 IDLE, 01 RUN, 10 FLUSH, 11 FAULT (FAULT used only with the optional feature).

Behaviour:
- Reset (reset=0, asynchronous) takes effect immediately:
  - state=IDLE, pc=RESET_PC, pc_valid=0, flush=0, flush counter=0.
- All outputs are registered. Every decision below takes effect on the next rising clk edge.
- IDLE:
  - pc holds RESET_PC.
  - start=1 → RUN, pc_valid=1, pc=RESET_PC (first fetch).
  - exc, br_taken and stall are ignored.
- RUN, priority is exc > br_taken > stall > sequential:
  - exc=1 → pc=EXC_VECTOR.
  - br_taken=1 → pc=br_target.
  - Either redirect → state=FLUSH, pc_valid=0, flush=1, counter=FLUSH_CYCLES-1.
  - stall=1 (no redirect) → pc, pc_valid=1 and state unchanged.
  - Otherwise pc=pc+4, truncated to 64 bits; 64'hFFFF_FFFF_FFFF_FFFC wraps to 64'h0.
- FLUSH:
  - pc held at the redirect target; pc_valid=0; flush=1.
  - Counter decrements each cycle. Counter=0 → RUN, pc_valid=1, flush=0, pc unchanged, so the target is fetched first.
  - Effective bubble length is exactly FLUSH_CYCLES cycles.
  - stall does not freeze the counter.
  - br_taken is ignored, since it comes from a wrong-path instruction.
  - exc=1 → pc=EXC_VECTOR and the counter reloads to FLUSH_CYCLES-1; state stays FLUSH.
- Simultaneous exc and br_taken → exception wins; br_target is discarded.
- br_taken with stall → redirect wins; stall only ever blocks sequential advance.
- start is ignored outside IDLE. There is no return to IDLE except via reset.
- Reset asserted mid-FLUSH or mid-RUN aborts immediately to the reset values. No state survives.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - A redirect whose target has target[1:0]≠2'b00 is not taken.
  - For br_target, that applies in RUN.
  - For EXC_VECTOR, it applies at any time (parameter misconfiguration).
  - Instead: state=FAULT, pc=EXC_VECTOR with bits [1:0] forced to 0, pc_valid=0, flush=1.
  - FAULT lasts FLUSH_CYCLES cycles using the same counter, then → RUN.
  - FAULT otherwise behaves as FLUSH; exc inside FAULT behaves as exc inside FLUSH.
- Not defined:
  - No check; the target is loaded verbatim.
  - state never encodes 11.
  - The FAULT logic is absent.

Test Plan:
- Reset/start: hold reset=0 2 cycles, release, idle 3 cycles, pulse start → pc=0, pc_valid=0 until start. One cycle after start: pc=0, pc_valid=1. Next cycles: pc=4, 8, 12.
- Stall: in RUN at pc=0x10, stall=1 for 3 cycles → pc stays 0x10 with pc_valid=1, resumes 0x14 after stall drops. Also assert reset=0 mid-clock-low → pc=0 immediately, without a clock edge.
- Branch redirect, FLUSH_CYCLES=2: at pc=0x20, br_taken=1 with target 0x400 → flush=1, pc_valid=0 for exactly 2 cycles, pc=0x400. Then pc_valid=1, pc=0x400, followed by 0x404. A br_taken pulse during FLUSH changes nothing.
- Priority: exc=1 and br_taken=1 (target 0x800) in the same cycle → pc=0x100, FLUSH. Separately, exc in the 2nd FLUSH cycle → pc=0x100 and the counter restarts, giving 2 more bubble cycles.
- Wrap: force a redirect to 64'hFFFF_FFFF_FFFF_FFF8 → after the flush, pc sequence is …FFF8, …FFFC, 0x0, 0x4.
- PC_ALIGN_CHECK_EN defined: br_taken with target 0x402 → state=11, pc=0x100, flush=1 for 2 cycles, then RUN at 0x100. Same stimulus without the macro → pc=0x402, state=10.
